// File: rtl/const_add_layer_if.sv
// Handshake and state bus between the Ascon round front-end and its neighbours.
// The slave modport is the constant-addition layer itself; the master modport is
// whatever drives it (the controller and the substitution/diffusion path).
// Optional macro CONST_ADD_LAYER_ABORT_EN adds the i_abort request line.
interface const_add_layer_if;
   logic                 i_valid;
   logic                 o_ready;
   logic [3:0]           i_rounds;
   logic [4:0][63:0]     i_state;
   logic [4:0][63:0]     i_fb_state;
   logic [4:0][63:0]     o_state;
   logic                 o_valid;
   logic                 i_ready;
   logic [3:0]           o_round;
   logic                 o_last;
   logic [4:0][63:0]     o_result;
   logic                 o_done;
   logic                 o_error;
`ifdef CONST_ADD_LAYER_ABORT_EN
   logic                 i_abort;
`endif

   modport slave (
      input  i_valid,
      output o_ready,
      input  i_rounds,
      input  i_state,
      input  i_fb_state,
      output o_state,
      output o_valid,
      input  i_ready,
      output o_round,
      output o_last,
      output o_result,
      output o_done,
`ifdef CONST_ADD_LAYER_ABORT_EN
      input  i_abort,
`endif
      output o_error
   );

   modport master (
      output i_valid,
      input  o_ready,
      output i_rounds,
      output i_state,
      output i_fb_state,
      input  o_state,
      input  o_valid,
      output i_ready,
      input  o_round,
      input  o_last,
      input  o_result,
      input  o_done,
`ifdef CONST_ADD_LAYER_ABORT_EN
      output i_abort,
`endif
      input  o_error
   );
endinterface

// File: rtl/const_add_layer.sv
// Iterative round front-end of the Ascon permutation: loads the 320-bit state,
// XORs the round constant into x2[7:0] each round and presents the registered
// result to the substitution layer, recapturing the diffusion output as the
// next round's input. Word k of a state array is xk (x0 at index 0).
// Optional macro CONST_ADD_LAYER_ABORT_EN adds an abort request that cancels
// a running permutation without producing a result.
module const_add_layer #(
   parameter int NUM_ROUNDS_MAX = 12,
   parameter int CONST_WIDTH    = 8
) (
   input logic               clock,
   input logic               reset,
   const_add_layer_if.slave  bus
);

   localparam logic [3:0] ROUNDS_MAX = 4'(NUM_ROUNDS_MAX);
   localparam logic [3:0] LAST_INDEX = 4'(NUM_ROUNDS_MAX - 1);

   typedef enum logic {IDLE, RUN} fsm_state_e;
   typedef logic [4:0][63:0] word_array_t;

   fsm_state_e  fsm_state, fsm_next;
   word_array_t round_state, round_state_next;
   word_array_t result_reg, result_next;
   logic [3:0]  round_index, round_index_next;
   logic [3:0]  start_index;
   logic        rounds_legal;
   logic        done_reg, done_next;
   logic        error_reg, error_next;
   logic        abort_req;

   // Constant for absolute round i: high nibble counts down from F, low nibble up from 0.
   function automatic logic [CONST_WIDTH-1:0] round_const(input logic [3:0] index);
      return CONST_WIDTH'({4'hF - index, index});
   endfunction

   // Only the low bits of x2 carry the constant; every other bit passes through.
   function automatic word_array_t add_const(input word_array_t s, input logic [3:0] index);
      word_array_t r;
      r = s;
      r[2][CONST_WIDTH-1:0] = s[2][CONST_WIDTH-1:0] ^ round_const(index);
      return r;
   endfunction

`ifdef CONST_ADD_LAYER_ABORT_EN
   assign abort_req = bus.i_abort;
`else
   assign abort_req = 1'b0;
`endif

   // p^a uses the last a constants of the schedule, so it starts at index 12-a.
   assign rounds_legal = (bus.i_rounds != 4'd0) && (bus.i_rounds <= ROUNDS_MAX);
   assign start_index  = ROUNDS_MAX - bus.i_rounds;

   // Next-state logic: start/error in IDLE, advance/complete/abort in RUN.
   always_comb begin
      fsm_next         = fsm_state;
      round_state_next = round_state;
      round_index_next = round_index;
      result_next      = result_reg;
      done_next        = 1'b0;
      error_next       = 1'b0;
      case (fsm_state)
         IDLE: begin
            if (bus.i_valid) begin
               if (rounds_legal) begin
                  round_index_next = start_index;
                  round_state_next = add_const(bus.i_state, start_index);
                  fsm_next         = RUN;
               end else begin
                  error_next = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort_req) begin
               round_index_next = 4'd0;
               fsm_next         = IDLE;
            end else if (bus.i_ready) begin
               if (round_index == LAST_INDEX) begin
                  result_next      = bus.i_fb_state;
                  done_next        = 1'b1;
                  round_index_next = 4'd0;
                  fsm_next         = IDLE;
               end else begin
                  round_index_next = round_index + 4'd1;
                  round_state_next = add_const(bus.i_fb_state, round_index + 4'd1);
               end
            end
         end
         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   // State register and all registered outputs, cleared immediately by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_state   <= IDLE;
         round_state <= '0;
         round_index <= 4'd0;
         result_reg  <= '0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
      end else begin
         fsm_state   <= fsm_next;
         round_state <= round_state_next;
         round_index <= round_index_next;
         result_reg  <= result_next;
         done_reg    <= done_next;
         error_reg   <= error_next;
      end
   end

   assign bus.o_ready  = (fsm_state == IDLE) && !reset;
   assign bus.o_valid  = (fsm_state == RUN);
   assign bus.o_state  = round_state;
   assign bus.o_round  = (fsm_state == RUN) ? round_index : 4'd0;
   assign bus.o_last   = (fsm_state == RUN) && (round_index == LAST_INDEX);
   assign bus.o_result = result_reg;
   assign bus.o_done   = done_reg;
   assign bus.o_error  = error_reg;

endmodule

// File: doc/const_add_layer.md
Name: const_add_layer

Overview:
- Iterative round front-end of the Ascon permutation core; sits directly upstream of the substitution layer.
- Loads a 320-bit state and runs a round counter for p^a, with a in 1..12.
- Each round, XORs the round constant into x2[7:0] and presents the registered result to the substitution/diffusion path.
- Recaptures the state fed back from the diffusion layer output and signals completion after the final round.

Parameters:
- NUM_ROUNDS_MAX, 12, total constant schedule length. Round index runs 0..NUM_ROUNDS_MAX-1.
- CONST_WIDTH, 8, width of the round constant XORed into the LSBs of x2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  start request: a new permutation is offered.
- o_ready  output  1  block is idle and can accept i_valid.
- i_rounds  input  4  number of rounds a; legal range 1..12.
- i_state  input  t_state_array  initial state (5 x 64-bit words x0..x4).
- i_fb_state  input  t_state_array  state returned from the diffusion layer output (combinational loop through sub and diffusion layers).
- o_state  output  t_state_array  registered state after constant addition; feeds the substitution layer.
- o_valid  output  1  o_state holds a valid round input.
- i_ready  input  1  downstream accepts the current round this cycle.
- o_round  output  4  absolute constant index i of the current round, 0..11.
- o_last  output  1  o_valid and o_round == 11.
- o_result  output  t_state_array  final permuted state, held until the next completion.
- o_done  output  1  one-cycle pulse: o_result has just been updated.
- o_error  output  1  one-cycle pulse: start request carried an illegal i_rounds.

Behaviour:
- Round constant: c(i) = {(4'hF - i), i[3:0]}, so i=0 -> 0xF0, i=6 -> 0x96, i=11 -> 0x4B. Only x2[7:0] is modified; x0, x1, x3, x4 and x2[63:8] pass through unchanged.
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state IDLE.
  - o_state and o_result = 0.
  - o_valid, o_done, o_error, o_last = 0.
  - o_round = 0.
  - o_ready = 1 once out of reset.
- FSM states: IDLE, RUN.
- IDLE:
  - o_ready = 1, o_valid = 0.
  - On i_valid with i_rounds in 1..12: set index = 12 - i_rounds, register o_state = i_state with x2[7:0] ^= c(index), set o_valid = 1, go to RUN.
  - On i_valid with i_rounds = 0 or > 12: no load, pulse o_error for 1 cycle, stay in IDLE.
- RUN:
  - o_ready = 0; i_valid is ignored.
  - o_valid is held at 1, and o_state is stable until the handshake (o_valid & i_ready).
  - Handshake on a round other than the last: o_state <= i_fb_state with x2[7:0] ^= c(index+1), and index increments.
  - Handshake on the last round (index == 11): o_result <= i_fb_state, o_done = 1 on the next cycle, o_valid = 0, go to IDLE.
- Latency: with i_ready held high, start is accepted at cycle 0, rounds occupy cycles 1..a, and o_done is asserted in cycle a+1. p12 therefore has 13-cycle latency and p6 has 7.
- Back-to-back: the next start may be accepted in the same cycle o_done is high, because the block is already in IDLE.
- Stalls: i_ready low stalls indefinitely with no state change.
- o_round and o_last are registered with o_state and valid only while o_valid = 1; o_round = 0 otherwise.

Optional Feature:
- Macro: CONST_ADD_LAYER_ABORT_EN.
- When defined:
  - Adds input port i_abort (1 bit).
  - i_abort high in RUN returns to IDLE on the next edge: o_valid = 0, o_result unchanged, no o_done.
  - In IDLE, i_abort is ignored.
  - If i_abort and a last-round handshake occur together, i_abort wins and no o_done is produced.
- When not defined: no i_abort port; a run can only end by completion or reset.

Test Plan:
- p12, all-zero i_state, i_ready tied 1, i_fb_state = o_state (identity loop) -> o_state x2[7:0] sequence is 0xF0, then 0xF0^0xE1=0x11, and so on; o_done in cycle 13; o_result x2[7:0] = XOR of all 12 constants = 0x00, all other words 0.
- p6 start -> o_round runs 6..11; first o_state x2[7:0] = 0x96; o_last only at o_round = 11; o_done in cycle 7.
- Random i_ready stalls during p8 -> o_state constant while stalled; o_done only after exactly 8 handshakes.
- i_rounds = 0 and then 13 -> o_error pulses, o_valid stays 0, o_ready stays 1.
- Reset asserted at round 5 of p12 -> all outputs 0 immediately, o_ready = 1 after release; a fresh p12 then completes correctly.
- With CONST_ADD_LAYER_ABORT_EN defined: i_abort at round 3 -> o_valid = 0 next cycle, no o_done, previous o_result retained.
